// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: counter sizing helper and the
// per-channel state encoding.
package debounce_pkg;

  // Channel state encoding.
  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  typedef enum logic {
    CH_STABLE  = ST_STABLE,
    CH_PENDING = ST_PENDING
  } ch_state_e;

  // Ceiling log2 of n with a floor of 1 bit, so the counter can hold n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single switch channel: SYNC_STAGES-deep synchronizer, stability counter,
// debounced level and registered one-cycle rise/fall strobes.
// The debug output o_state reports STABLE / PENDING for the channel.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic      i_clk,
  input  logic      i_ar,
  input  logic      i_switch,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_fall,
  output ch_state_e o_state
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Channel is PENDING whenever the synchronized input disagrees with the
  // debounced level; any bounce back makes it STABLE again immediately.
  assign o_state = (s != level_q) ? CH_PENDING : CH_STABLE;

  // Register all channel state; everything clears asynchronously on i_ar low.
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_switch};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state: count consecutive disagreeing cycles, flip on the last one.
  // The counter stops at CNT_MAX and is cleared on the flip, so it never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (o_state)
      CH_STABLE: begin
        cnt_d = '0;
      end
      CH_PENDING: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// WIDTH independent switch debouncers with clean levels and one-cycle
// rise/fall strobes, all synchronous to i_clk.
// Optional status outputs (o_busy, o_changed) are built when the macro
// SWITCH_DEBOUNCE_STATUS_EN is defined.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             i_clk,
  input  logic             i_ar,
  input  logic [WIDTH-1:0] i_switches,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
`ifdef SWITCH_DEBOUNCE_STATUS_EN
  output logic [WIDTH-1:0] o_fall,
  output logic             o_busy,
  output logic             o_changed
`else
  output logic [WIDTH-1:0] o_fall
`endif
);

  logic [WIDTH-1:0] pending;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    ch_state_e ch_state;

    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_bit (
      .i_clk   (i_clk),
      .i_ar    (i_ar),
      .i_switch(i_switches[g]),
      .o_level (o_level[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g]),
      .o_state (ch_state)
    );

    assign pending[g] = (ch_state == CH_PENDING);
  end

`ifdef SWITCH_DEBOUNCE_STATUS_EN
  logic changed_q;

  assign o_busy = |pending;

  // Any strobe on any channel is reported one cycle later for one cycle.
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |(o_rise | o_fall);
    end
  end

  assign o_changed = changed_q;
`else
  logic unused_pending;
  assign unused_pending = ^pending;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=8, SYNC_STAGES=2,
// WIDTH=6. Cycle c means "just after the c-th rising edge following the
// input change"; a clean edge shows on o_level at c=10.
module tb_switch_debounce;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned STABLE = 8;
  localparam int unsigned SYNC   = 2;

  logic             i_clk = 1'b0;
  logic             i_ar  = 1'b0;
  logic [WIDTH-1:0] i_switches = '0;
  logic [WIDTH-1:0] o_level;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;

  int errors = 0;
  int checks = 0;

  switch_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .i_clk     (i_clk),
    .i_ar      (i_ar),
    .i_switches(i_switches),
    .o_level   (o_level),
    .o_rise    (o_rise),
    .o_fall    (o_fall)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    logic [WIDTH-1:0] el, er;
    i_ar = 1'b0;
    i_switches = 6'h3F;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({o_level, o_rise, o_fall} !== 18'h0) begin
        errors++;
        $display("FAIL reset_hold c=%0d got lvl=%h rise=%h fall=%h want all 0", c, o_level, o_rise, o_fall);
      end
    end
    i_ar = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'h3F : 6'h00;
      er = (c == 10) ? 6'h3F : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, 6'h00}) begin
        errors++;
        $display("FAIL reset_release c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=00",
                 c, o_level, o_rise, o_fall, el, er);
      end
    end
  endtask

  task automatic test_fall_all;
    logic [WIDTH-1:0] el, ef;
    i_switches = 6'h00;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'h00 : 6'h3F;
      ef = (c == 10) ? 6'h3F : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, 6'h00, ef}) begin
        errors++;
        $display("FAIL fall_all c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=00 fall=%h",
                 c, o_level, o_rise, o_fall, el, ef);
      end
    end
  endtask

  task automatic test_clean_edge;
    logic [WIDTH-1:0] el, er, ef;
    i_switches = 6'h04;
    for (int c = 1; c <= 12; c++) begin
      tick();
      el = (c >= 10) ? 6'h04 : 6'h00;
      er = (c == 10) ? 6'h04 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, 6'h00}) begin
        errors++;
        $display("FAIL clean_rise c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=00",
                 c, o_level, o_rise, o_fall, el, er);
      end
    end
    i_switches = 6'h00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      el = (c >= 10) ? 6'h00 : 6'h04;
      ef = (c == 10) ? 6'h04 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, 6'h00, ef}) begin
        errors++;
        $display("FAIL clean_fall c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=00 fall=%h",
                 c, o_level, o_rise, o_fall, el, ef);
      end
    end
  endtask

  task automatic test_bounce;
    logic [WIDTH-1:0] el, er, ef;
    // 17 full periods of high-3 / low-3, ending low.
    for (int c = 0; c < 102; c++) begin
      i_switches[0] = ((c % 6) < 3);
      tick();
      checks++;
      if ({o_level, o_rise, o_fall} !== 18'h0) begin
        errors++;
        $display("FAIL bounce c=%0d got lvl=%h rise=%h fall=%h want all 0", c, o_level, o_rise, o_fall);
      end
    end
    i_switches[0] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'h01 : 6'h00;
      er = (c == 10) ? 6'h01 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, 6'h00}) begin
        errors++;
        $display("FAIL bounce_settle c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=00",
                 c, o_level, o_rise, o_fall, el, er);
      end
    end
    i_switches[0] = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'h00 : 6'h01;
      ef = (c == 10) ? 6'h01 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, 6'h00, ef}) begin
        errors++;
        $display("FAIL bounce_release c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=00 fall=%h",
                 c, o_level, o_rise, o_fall, el, ef);
      end
    end
  endtask

  task automatic test_threshold;
    logic [WIDTH-1:0] el, er, ef;
    // High for STABLE-1 sampled cycles: must be rejected.
    i_switches[5] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 7) i_switches[5] = 1'b0;
      checks++;
      if ({o_level, o_rise, o_fall} !== 18'h0) begin
        errors++;
        $display("FAIL glitch_short c=%0d got lvl=%h rise=%h fall=%h want all 0", c, o_level, o_rise, o_fall);
      end
    end
    // High for exactly STABLE sampled cycles: accepted, then the low that
    // follows is itself debounced (rise at c=10, fall at c=18).
    i_switches[5] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 8) i_switches[5] = 1'b0;
      el = (c >= 10 && c < 18) ? 6'h20 : 6'h00;
      er = (c == 10) ? 6'h20 : 6'h00;
      ef = (c == 18) ? 6'h20 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, ef}) begin
        errors++;
        $display("FAIL glitch_exact c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=%h",
                 c, o_level, o_rise, o_fall, el, er, ef);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [WIDTH-1:0] el, er, ef;
    i_switches = 6'b010010;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'b010010 : 6'h00;
      er = (c == 10) ? 6'b010010 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, 6'h00}) begin
        errors++;
        $display("FAIL simul_rise c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=00",
                 c, o_level, o_rise, o_fall, el, er);
      end
    end
    i_switches = 6'h00;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'h00 : 6'b010010;
      ef = (c == 10) ? 6'b010010 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, 6'h00, ef}) begin
        errors++;
        $display("FAIL simul_fall c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=00 fall=%h",
                 c, o_level, o_rise, o_fall, el, ef);
      end
    end
  endtask

  task automatic test_reset_midop;
    logic [WIDTH-1:0] el, er;
    i_switches = 6'b010010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({o_level, o_rise, o_fall} !== 18'h0) begin
        errors++;
        $display("FAIL midop_pending c=%0d got lvl=%h rise=%h fall=%h want all 0", c, o_level, o_rise, o_fall);
      end
    end
    i_ar = 1'b0;
    #1;
    checks++;
    if ({o_level, o_rise, o_fall} !== 18'h0) begin
      errors++;
      $display("FAIL midop_async_clear got lvl=%h rise=%h fall=%h want all 0", o_level, o_rise, o_fall);
    end
    tick();
    tick();
    i_ar = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      el = (c >= 10) ? 6'b010010 : 6'h00;
      er = (c == 10) ? 6'b010010 : 6'h00;
      checks++;
      if ({o_level, o_rise, o_fall} !== {el, er, 6'h00}) begin
        errors++;
        $display("FAIL midop_release c=%0d got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=00",
                 c, o_level, o_rise, o_fall, el, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_all();
    test_clean_edge();
    test_bounce();
    test_threshold();
    test_simultaneous();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
